// File: rtl/mac_os_rx_decoder_pkg.sv
// Shared ordered-set definitions: symbol codes, completed-set types, rx FSM states.
// Also carries the saturating increment used by the statistics counters.
`ifndef OZDEFS_SV
`define OZDEFS_SV
`define COM   8'hBC
`define SKP   8'h1C
`define TS1ID 8'h4A
`define TS2ID 8'h45
`endif

package mac_os_rx_decoder_pkg;

    typedef enum logic [1:0] {
        OS_NONE = 2'd0,
        OS_SKP  = 2'd1,
        OS_TS1  = 2'd2,
        OS_TS2  = 2'd3
    } os_type_e;

    typedef logic [1:0] os_rx_state_e;

    localparam os_rx_state_e ST_IDLE     = 2'd0;
    localparam os_rx_state_e ST_TYPE     = 2'd1;
    localparam os_rx_state_e ST_SKP_BODY = 2'd2;
    localparam os_rx_state_e ST_TS_BODY  = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mac_os_rx_consec_tracker.sv
// Counts consecutive identical good TS sets (same kind, same bytes 1-5).
// Latency 1 from the completion strobe; count and hit line up with os_done.
module mac_os_rx_consec_tracker
    import mac_os_rx_decoder_pkg::*;
#(
    parameter int CONSEC_TARGET = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done,
    input  logic             clear,
    input  os_type_e         kind,
    input  logic [39:0]      bytes,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TARGET  = CNT_W'(CONSEC_TARGET);

    os_type_e         prev_kind;
    logic [39:0]      prev_bytes;
    logic             same;
    logic             held;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        same    = (kind == prev_kind) && (bytes == prev_bytes);
        held    = same && (cnt == CNT_MAX);
        cnt_nxt = CNT_ONE;
        if (same) begin
            cnt_nxt = held ? cnt : cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_kind  <= OS_NONE;
            prev_bytes <= '0;
            cnt        <= '0;
            hit        <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (done) begin
                prev_kind  <= kind;
                prev_bytes <= bytes;
                cnt        <= cnt_nxt;
                // a saturated count is not a new arrival at the target
                hit        <= (cnt_nxt == TARGET) && !held;
            end
        end
    end

endmodule

// File: rtl/mac_os_rx_decoder.sv
// Byte-serial SKP/TS1/TS2 ordered-set receiver; results registered one cycle after the last byte.
// rxvalid=0 stalls the parser in place. Optional counters: MAC_OS_RX_STATS_EN.
module mac_os_rx_decoder
    import mac_os_rx_decoder_pkg::*;
#(
    parameter int CONSEC_TARGET = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rxdata,
    input  logic             rxdatak,
    input  logic             rxvalid,
    output logic             os_done,
    output os_type_e         os_type,
    output logic [39:0]      ts_bytes,
    output logic [CNT_W-1:0] ts_consec_cnt,
    output logic             ts_consec_hit,
    output logic             os_err,
    output logic [15:0]      stat_skp,
    output logic [15:0]      stat_ts1,
    output logic [15:0]      stat_ts2,
    output logic [15:0]      stat_err
);
    os_rx_state_e state, state_nxt;
    logic [3:0]   idx, idx_nxt;
    logic [39:0]  cap;
    logic         ts2_kind;
    logic         is_com, is_skp, is_id, id_ok;
    logic         ts_fin, skp_fin, err_now;
    os_type_e     kind_cur;

    always_comb begin
        is_com    = rxdatak && (rxdata == `COM);
        is_skp    = rxdatak && (rxdata == `SKP);
        is_id     = !rxdatak && ((rxdata == `TS1ID) || (rxdata == `TS2ID));
        id_ok     = !rxdatak && (rxdata == (ts2_kind ? `TS2ID : `TS1ID));
        kind_cur  = ts2_kind ? OS_TS2 : OS_TS1;
        state_nxt = state;
        idx_nxt   = idx;
        ts_fin    = 1'b0;
        skp_fin   = 1'b0;
        err_now   = 1'b0;
        if (rxvalid) begin
            case (state)
                ST_IDLE: begin
                    if (is_com) state_nxt = ST_TYPE;
                end
                ST_TYPE: begin
                    idx_nxt   = 4'd2;
                    state_nxt = is_skp ? ST_SKP_BODY : ST_TS_BODY;
                end
                ST_SKP_BODY: begin
                    if (is_com) begin
                        err_now   = 1'b1;
                        state_nxt = ST_TYPE;
                    end else if (!is_skp) begin
                        err_now   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (idx == 4'd3) begin
                        skp_fin   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
                default: begin
                    // TS body: bytes 2..5 free, byte 6 picks the kind, 7..15 repeat it
                    if (is_com) begin
                        err_now   = 1'b1;
                        state_nxt = ST_TYPE;
                    end else if ((idx == 4'd6 && !is_id) || (idx >= 4'd7 && !id_ok)) begin
                        err_now   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (idx == 4'd15) begin
                        ts_fin    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= 4'd0;
            cap      <= '0;
            ts2_kind <= 1'b0;
            os_done  <= 1'b0;
            os_err   <= 1'b0;
            os_type  <= OS_NONE;
            ts_bytes <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            os_done <= skp_fin || ts_fin;
            os_err  <= err_now;
            if (rxvalid && state == ST_TYPE && !is_skp) cap[7:0] <= rxdata;
            if (rxvalid && state == ST_TS_BODY && !is_com) begin
                case (idx)
                    4'd2:    cap[15:8]  <= rxdata;
                    4'd3:    cap[23:16] <= rxdata;
                    4'd4:    cap[31:24] <= rxdata;
                    4'd5:    cap[39:32] <= rxdata;
                    4'd6:    ts2_kind   <= (rxdata == `TS2ID);
                    default: ;
                endcase
            end
            if (skp_fin) os_type <= OS_SKP;
            if (ts_fin) begin
                os_type  <= kind_cur;
                ts_bytes <= cap;
            end
        end
    end

    mac_os_rx_consec_tracker #(
        .CONSEC_TARGET (CONSEC_TARGET),
        .CNT_W         (CNT_W)
    ) u_consec (
        .clk   (clk),
        .rst   (rst),
        .done  (ts_fin),
        .clear (err_now),
        .kind  (kind_cur),
        .bytes (cap),
        .cnt   (ts_consec_cnt),
        .hit   (ts_consec_hit)
    );

`ifdef MAC_OS_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_skp <= '0;
            stat_ts1 <= '0;
            stat_ts2 <= '0;
            stat_err <= '0;
        end else begin
            if (os_done && os_type == OS_SKP) stat_skp <= sat_inc16(stat_skp);
            if (os_done && os_type == OS_TS1) stat_ts1 <= sat_inc16(stat_ts1);
            if (os_done && os_type == OS_TS2) stat_ts2 <= sat_inc16(stat_ts2);
            if (os_err)                       stat_err <= sat_inc16(stat_err);
        end
    end
`else
    assign stat_skp = '0;
    assign stat_ts1 = '0;
    assign stat_ts2 = '0;
    assign stat_err = '0;
`endif

endmodule

// File: tb/tb_mac_os_rx_decoder.sv
// Directed bench for mac_os_rx_decoder: expected completions queued at send time, checked on output.
module tb_mac_os_rx_decoder;
    localparam logic [7:0] C_COM = 8'hBC;
    localparam logic [7:0] C_SKP = 8'h1C;
    localparam logic [7:0] C_TS1 = 8'h4A;
    localparam logic [7:0] C_TS2 = 8'h45;
    localparam logic [39:0] TSB  = 40'h00_02_10_F7_F7;

    logic        clk = 1'b0;
    logic        rst, rxdatak, rxvalid;
    logic [7:0]  rxdata;
    logic        os_done, os_err, ts_consec_hit;
    logic [1:0]  os_type;
    logic [39:0] ts_bytes;
    logic [7:0]  ts_consec_cnt;
    logic [15:0] stat_skp, stat_ts1, stat_ts2, stat_err;

    mac_os_rx_decoder #(.CONSEC_TARGET(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rxdata(rxdata), .rxdatak(rxdatak), .rxvalid(rxvalid),
        .os_done(os_done), .os_type(os_type), .ts_bytes(ts_bytes),
        .ts_consec_cnt(ts_consec_cnt), .ts_consec_hit(ts_consec_hit), .os_err(os_err),
        .stat_skp(stat_skp), .stat_ts1(stat_ts1), .stat_ts2(stat_ts2), .stat_err(stat_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [1:0]  typ;
        logic [39:0] bytes;
        logic [7:0]  cnt;
        logic        hit;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cyc = 0;
    int c0;

    logic [1:0]  m_kind;
    logic [39:0] m_bytes, m_last;
    logic [7:0]  m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            chk("done_err_exclusive", {63'd0, os_done & os_err}, 64'd0);
            if (os_done || os_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("is_err", {63'd0, os_err}, {63'd0, e.err});
                    chk("cnt", {56'd0, ts_consec_cnt}, {56'd0, e.cnt});
                    chk("hit", {63'd0, ts_consec_hit}, {63'd0, e.hit});
                    if (!e.err) begin
                        chk("os_type", {62'd0, os_type}, {62'd0, e.typ});
                        chk("ts_bytes", {24'd0, ts_bytes}, {24'd0, e.bytes});
                        done_cyc = cyc;
                    end
                end
            end else begin
                chk("stray_hit", {63'd0, ts_consec_hit}, 64'd0);
            end
        end
    end

    task automatic model_reset();
        m_kind = 2'd0; m_bytes = '0; m_last = '0; m_cnt = 8'd0;
    endtask

    task automatic push_ts(input logic [1:0] kind, input logic [39:0] b);
        exp_t x;
        logic hold;
        hold = (kind == m_kind) && (b == m_bytes) && (m_cnt == 8'hFF);
        if (kind == m_kind && b == m_bytes) m_cnt = hold ? m_cnt : m_cnt + 8'd1;
        else m_cnt = 8'd1;
        m_kind = kind; m_bytes = b; m_last = b;
        x.err = 1'b0; x.typ = kind; x.bytes = b; x.cnt = m_cnt;
        x.hit = (m_cnt == 8'd8) && !hold;
        q.push_back(x);
    endtask

    task automatic push_skp();
        exp_t x;
        x.err = 1'b0; x.typ = 2'd1; x.bytes = m_last; x.cnt = m_cnt; x.hit = 1'b0;
        q.push_back(x);
    endtask

    task automatic push_err();
        exp_t x;
        m_cnt = 8'd0;
        x.err = 1'b1; x.typ = 2'd0; x.bytes = '0; x.cnt = 8'd0; x.hit = 1'b0;
        q.push_back(x);
    endtask

    task automatic sym(input logic [7:0] d, input logic k);
        rxdata = d; rxdatak = k; rxvalid = 1'b1;
        @(posedge clk); #1;
        rxvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    // bad_idx in 7..15 replaces that byte with the other kind's ID
    task automatic send_ts(input logic [7:0] id, input logic [39:0] b, input int stall_after, input int bad_idx);
        sym(C_COM, 1'b1);
        for (int i = 0; i < 5; i++) sym(b[i*8 +: 8], 1'b0);
        for (int i = 6; i <= 15; i++) begin
            sym((i == bad_idx) ? ((id == C_TS1) ? C_TS2 : C_TS1) : id, 1'b0);
            if (i == stall_after) begin
                rxdata = C_COM; rxdatak = 1'b1;
                idle(3);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) begin @(posedge clk); #1; end
        chk("drain_timeout", 64'(q.size()), 64'd0);
        idle(2);
    endtask

    task automatic check_stats(input int s, input int t1, input int t2, input int er);
`ifdef MAC_OS_RX_STATS_EN
        chk("stat_skp", {48'd0, stat_skp}, 64'(s));
        chk("stat_ts1", {48'd0, stat_ts1}, 64'(t1));
        chk("stat_ts2", {48'd0, stat_ts2}, 64'(t2));
        chk("stat_err", {48'd0, stat_err}, 64'(er));
`else
        chk("stat_skp", {48'd0, stat_skp}, 64'd0 & 64'(s));
        chk("stat_ts1", {48'd0, stat_ts1}, 64'd0 & 64'(t1));
        chk("stat_ts2", {48'd0, stat_ts2}, 64'd0 & 64'(t2));
        chk("stat_err", {48'd0, stat_err}, 64'd0 & 64'(er));
`endif
    endtask

    initial begin
        rst = 1'b1; rxvalid = 1'b0; rxdata = 8'h00; rxdatak = 1'b0;
        model_reset();
        idle(3);
        rst = 1'b0;
        chk("rst_os_done", {63'd0, os_done}, 64'd0);
        chk("rst_os_err", {63'd0, os_err}, 64'd0);
        chk("rst_os_type", {62'd0, os_type}, 64'd0);
        chk("rst_ts_bytes", {24'd0, ts_bytes}, 64'd0);
        chk("rst_cnt", {56'd0, ts_consec_cnt}, 64'd0);
        check_stats(0, 0, 0, 0);

        // garbage before COM is ignored silently
        sym(8'h55, 1'b0); sym(C_SKP, 1'b1);
        idle(2);

        c0 = cyc;
        push_skp();
        sym(C_COM, 1'b1); sym(C_SKP, 1'b1); sym(C_SKP, 1'b1); sym(C_SKP, 1'b1);
        drain();
        chk("skp_latency", 64'(done_cyc - c0), 64'd4);

        for (int n = 0; n < 8; n++) begin
            push_ts(2'd2, TSB);
            send_ts(C_TS1, TSB, 0, 0);
        end
        drain();
        chk("cnt_after_8", {56'd0, ts_consec_cnt}, 64'd8);

        c0 = cyc;
        push_ts(2'd3, TSB);
        send_ts(C_TS2, TSB, 0, 0);
        drain();
        chk("ts2_latency", 64'(done_cyc - c0), 64'd16);

        c0 = cyc;
        push_ts(2'd3, TSB);
        send_ts(C_TS2, TSB, 9, 0);
        drain();
        chk("stall_latency", 64'(done_cyc - c0), 64'd19);

        push_err();
        send_ts(C_TS1, TSB, 0, 11);
        drain();
        chk("cnt_after_err", {56'd0, ts_consec_cnt}, 64'd0);

        push_err();
        push_skp();
        sym(C_COM, 1'b1); sym(8'hF7, 1'b0); sym(8'hF7, 1'b0);
        sym(C_COM, 1'b1); sym(C_SKP, 1'b1); sym(C_SKP, 1'b1); sym(C_SKP, 1'b1);
        drain();
        chk("type_after_resync", {62'd0, os_type}, 64'd1);
        check_stats(2, 8, 2, 2);

        // reset lands on byte 8 of a TS1
        sym(C_COM, 1'b1);
        for (int i = 0; i < 5; i++) sym(TSB[i*8 +: 8], 1'b0);
        sym(C_TS1, 1'b0); sym(C_TS1, 1'b0);
        rxdata = C_TS1; rxdatak = 1'b0; rxvalid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rxvalid = 1'b0;
        model_reset();
        chk("rst2_cnt", {56'd0, ts_consec_cnt}, 64'd0);
        chk("rst2_os_type", {62'd0, os_type}, 64'd0);
        check_stats(0, 0, 0, 0);
        idle(3);

        push_ts(2'd2, TSB);
        send_ts(C_TS1, TSB, 0, 0);
        drain();
        chk("cnt_after_rst_ts1", {56'd0, ts_consec_cnt}, 64'd1);
        check_stats(0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_os_rx_decoder.md
Name: mac_os_rx_decoder

Overview:
- MAC-side byte-serial receiver for the PHY→MAC rx symbol stream (rxdata/rxdatak/rxvalid).
- Parses SKP, TS1 and TS2 ordered sets and extracts TS bytes 1–5.
- Tracks consecutive identical TS sets and flags malformed sets.
- Feeds the MAC LTSSM transition logic; it is the consumer of what the PHY-side ordered-set driver emits.

Parameters:
- CONSEC_TARGET, 8: number of consecutive identical TS sets that fires ts_consec_hit (legal 1..255).
- CNT_W, 8: width of the consecutive-TS counter; saturates at all-ones.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rxdata  in  8  received symbol.
- rxdatak  in  1  1 = K symbol.
- rxvalid  in  1  symbol valid; low = stall.
- os_done  out  1  one-cycle pulse: a well-formed ordered set has completed.
- os_type  out  2  os_type_e of the last completed set; held until the next completion.
- ts_bytes  out  40  bytes 1–5 of the last good TS; byte1 in [7:0] … byte5 in [39:32].
- ts_consec_cnt  out  CNT_W  count of consecutive identical TS sets.
- ts_consec_hit  out  1  one-cycle pulse when the count becomes CONSEC_TARGET.
- os_err  out  1  one-cycle pulse on a malformed set.
- stat_skp, stat_ts1, stat_ts2, stat_err  out  16 each  statistics counters (see Optional Feature).

Behaviour:
- Reset, synchronous on rst=1: all outputs 0, os_type=OS_NONE, FSM=IDLE, internal byte index 0, stored previous TS cleared.
- A symbol is consumed only when rxvalid=1. When rxvalid=0, FSM, index and captured bytes hold unchanged.
- FSM states:
  - IDLE: wait for COM (rxdata=`COM, rxdatak=1). Any other symbol is ignored silently, with no error. On COM go to TYPE.
  - TYPE: `SKP with k=1 → SKP_BODY, idx=2. Any other symbol → TS_BODY; capture it as byte1, idx=2.
  - SKP_BODY: expect `SKP with k=1 at idx 2 and 3. At idx 3 → DONE_SKP.
  - TS_BODY:
    - idx 2..5: capture any symbol.
    - idx 6: data `TS1ID or `TS2ID latches the TS kind.
    - idx 7..15: must be data equal to the latched ID.
    - At idx 15 → completion.
- Completion:
  - os_done, os_type and ts_bytes (TS only) are registered and assert the cycle after the final byte is accepted (latency 1).
  - FSM returns to IDLE in the same cycle as the final byte.
- Error: any mismatch in SKP_BODY or TS_BODY idx ≥ 6 → os_err pulse next cycle, FSM to IDLE, ts_consec_cnt cleared.
- COM mid-set (k=1 `COM in any body state): os_err pulses and the FSM goes directly to TYPE (resync), so this COM starts a new set.
- Consecutive tracking:
  - Good TS with same kind and same bytes1–5 as the previous good TS → count+1, saturating at 2^CNT_W−1.
  - Otherwise the count is set to 1.
  - SKP completion leaves the count unchanged.
  - ts_consec_hit pulses on the same cycle as os_done, only when the new count equals CONSEC_TARGET. It does not re-fire while saturated or above target.
- rst mid-set: set discarded, no os_err, no os_done.
- os_done and os_err are never simultaneously 1.

Optional Feature:
- Macro: MAC_OS_RX_STATS_EN.
- With it defined: stat_* are 16-bit counters, each incremented on the cycle its os_done (by os_type) or os_err pulses. They saturate at 0xFFFF and clear on rst.
- Without it: stat_* are tied to 0 and no counter flops exist.

Decomposition:
- Shared defs (ozdefs.sv):
  - `COM, `SKP, `TS1ID, `TS2ID, already present.
  - Add typedef enum logic[1:0] os_type_e {OS_NONE, OS_SKP, OS_TS1, OS_TS2}.
  - Add the FSM state typedef os_rx_state_e.
- One sub-module: mac_os_rx_consec_tracker. It holds the previous kind and bytes1–5, the count, and generates the hit pulse. Its inputs are the completion strobe, kind and bytes.

Test Plan:
- SKP: COM,SKP,SKP,SKP with continuous rxvalid → os_done=1 one cycle after the last SKP, os_type=OS_SKP, os_err=0.
- TS1 ×8: COM, bytes1–5 = 0xF7,0xF7,0x10,0x02,0x00 (ts_bytes=0x0002_10F7_F7), ten `TS1ID, sent eight times → ts_consec_cnt 1..8, ts_consec_hit exactly once with the 8th os_done.
- Change: 8 TS1 followed by one TS2 with identical bytes → count resets to 1, os_type=OS_TS2, no hit.
- Stall: TS2 with rxvalid=0 for 3 cycles after byte 9 → same result as unstalled, os_done delayed by exactly 3 cycles.
- Malformed: TS1 whose byte 11 is 0x45 → os_err pulse, count cleared to 0, no os_done. Mid-set COM then SKP,SKP,SKP → os_err, then good SKP os_done.
- Reset: rst=1 at TS byte 8, release, send a full TS1 → exactly one os_done, count=1. With MAC_OS_RX_STATS_EN defined, stat_ts1=1 after the full TS1 and all stat_* read 0 after rst.
